// File: rtl/anim_sequencer.sv
// anim_sequencer: sprite-animation frame sequencer.
// A clock divider produces the frame-step tick; a small FSM (IDLE/PLAY/PAUSE/DONE)
// steps the frame index in loop, ping-pong, one-shot or hold mode, and a
// registered sprite-ROM address {frame, pix_y, pix_x} is produced for the pixel path.
// Optional build macro ANIM_SEQUENCER_FRAME_SYNC_EN adds a vsync input; the
// displayed frame then only updates on vsync to avoid mid-screen tearing.
module anim_sequencer #(
  parameter int FRAMES   = 16,
  parameter int TICK_DIV = 33554432,
  parameter int ADDR_X_W = 8,
  parameter int ADDR_Y_W = 8,
  localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 stop,
  input  logic                                 pause,
  input  logic [1:0]                           mode,
  input  logic [ADDR_X_W-1:0]                  pix_x,
  input  logic [ADDR_Y_W-1:0]                  pix_y,
`ifdef ANIM_SEQUENCER_FRAME_SYNC_EN
  input  logic                                 vsync,
`endif
  output logic [FRAME_W-1:0]                   frame,
  output logic [FRAME_W+ADDR_Y_W+ADDR_X_W-1:0] rom_addr,
  output logic                                 busy,
  output logic                                 step_tick,
  output logic                                 done
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]   LAST    = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   LAST_M1 = CNT_W'(TICK_DIV - 2);
  localparam logic [CNT_W-1:0]   C_ONE   = CNT_W'(1);
  localparam logic [FRAME_W-1:0] F_LAST  = FRAME_W'(FRAMES - 1);
  localparam logic [FRAME_W-1:0] F_ONE   = FRAME_W'(1);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;
  typedef enum logic [1:0] {M_LOOP, M_PING, M_ONCE, M_HOLD} mode_t;

  state_t             state;
  mode_t              mode_q;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] frame_i;
  logic               dir_up;

  // Playback FSM: divider, frame stepping and registered status pulses.
  // step_tick is registered one cycle ahead so it is high exactly during the
  // PLAY cycle whose counter value is LAST. A step already announced by
  // step_tick completes even if pause rises in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= M_LOOP;
      cnt       <= '0;
      frame_i   <= '0;
      dir_up    <= 1'b1;
      busy      <= 1'b0;
      step_tick <= 1'b0;
      done      <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      done      <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        cnt     <= '0;
        frame_i <= '0;
        dir_up  <= 1'b1;
        busy    <= 1'b0;
      end else if (start) begin
        state   <= PLAY;
        mode_q  <= mode_t'(mode);
        cnt     <= '0;
        frame_i <= '0;
        dir_up  <= 1'b1;
        busy    <= 1'b1;
      end else begin
        unique case (state)
          PLAY: begin
            state     <= pause ? PAUSE : PLAY;
            step_tick <= !pause && (cnt == LAST_M1);
            if (cnt == LAST) begin
              cnt <= '0;
              unique case (mode_q)
                M_LOOP: frame_i <= (frame_i == F_LAST) ? '0 : frame_i + F_ONE;
                M_PING: begin
                  if (FRAMES > 1) begin
                    if (dir_up) begin
                      if (frame_i == F_LAST) begin
                        dir_up  <= 1'b0;
                        frame_i <= frame_i - F_ONE;
                      end else begin
                        frame_i <= frame_i + F_ONE;
                      end
                    end else begin
                      if (frame_i == '0) begin
                        dir_up  <= 1'b1;
                        frame_i <= frame_i + F_ONE;
                      end else begin
                        frame_i <= frame_i - F_ONE;
                      end
                    end
                  end
                end
                M_ONCE: begin
                  if (frame_i == F_LAST) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                  end else begin
                    frame_i <= frame_i + F_ONE;
                  end
                end
                M_HOLD: frame_i <= frame_i;
              endcase
            end else if (!pause) begin
              cnt <= cnt + C_ONE;
            end
          end
          PAUSE: begin
            if (!pause) begin
              state     <= PLAY;
              step_tick <= (cnt == LAST);
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

`ifdef ANIM_SEQUENCER_FRAME_SYNC_EN
  logic [FRAME_W-1:0] frame_disp;

  // Displayed frame: loaded from the internal index only on vsync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             frame_disp <= '0;
    else if (stop || start) frame_disp <= '0;
    else if (vsync)         frame_disp <= frame_i;
  end

  assign frame = frame_disp;
`else
  assign frame = frame_i;
`endif

  // Sprite-ROM address, registered every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rom_addr <= '0;
    else        rom_addr <= {frame, pix_y, pix_x};
  end

endmodule

// File: doc/anim_sequencer.md
Name: anim_sequencer

Overview:
- Parametrised sprite-animation frame sequencer; successor to the fixed 16-step, free-running animation stepper.
- Derives a frame-advance tick from the system clock by an internal divider and steps a frame index under a small control state machine.
- Supports loop, ping-pong, one-shot and hold modes, with start/stop/pause control.
- Emits a registered sprite-ROM address {frame, pix_y, pix_x} for the VGA pixel path.

Parameters:
- FRAMES, 16: number of animation frames (>=1); FRAME_W = max(1, $clog2(FRAMES)).
- TICK_DIV, 33554432: clk cycles per frame step (>=2).
- ADDR_X_W, 8: pixel x address width.
- ADDR_Y_W, 8: pixel y address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; (re)start playback from frame 0.
- stop  in  1  1-cycle pulse; abort playback to IDLE.
- pause  in  1  level; freeze playback while high.
- mode  in  2  00 loop, 01 ping-pong, 10 one-shot, 11 hold; latched at start.
- pix_x  in  ADDR_X_W  current pixel x.
- pix_y  in  ADDR_Y_W  current pixel y.
- frame  out  FRAME_W  displayed frame index.
- rom_addr  out  FRAME_W+ADDR_Y_W+ADDR_X_W  registered {frame, pix_y, pix_x}.
- busy  out  1  high in PLAY or PAUSE.
- step_tick  out  1  1-cycle pulse on each frame step.
- done  out  1  1-cycle pulse on one-shot completion.

Behaviour:
- Reset (rst_n low, async): state IDLE, frame 0, dir up, tick counter 0, latched mode 00, rom_addr 0, busy/step_tick/done 0.
- States: IDLE, PLAY, PAUSE, DONE. Priority within a cycle: stop > start > pause.
- stop (any state) -> IDLE; frame 0, counter 0, dir up.
- start (any state, no stop) -> PLAY; frame 0, counter 0, dir up, mode latched. Asserting start in PLAY restarts playback.
- PLAY & pause=1 -> PAUSE. PAUSE & pause=0 -> PLAY. Counter holds in PAUSE.
- start in IDLE/DONE with pause=1 enters PLAY, then moves to PAUSE on the next cycle.
- Tick counter increments each PLAY cycle and wraps at TICK_DIV-1.
- step_tick is high combinationally-registered during the PLAY cycle where counter==TICK_DIV-1. The frame updates at the end of that cycle, so frame 1 is visible exactly TICK_DIV cycles after the start edge.
- Frame step by latched mode:
  - Loop: FRAMES-1 -> 0, else +1.
  - Ping-pong: dir up at FRAMES-1 -> dir down, frame-1. Dir down at 0 -> dir up, frame+1. FRAMES==1 keeps frame 0.
  - One-shot: frame<FRAMES-1 -> +1. Frame==FRAMES-1 -> frame holds, state DONE, done=1 for that one cycle.
  - Hold: frame unchanged; step_tick still pulses.
- DONE: busy 0, frame holds last value; only start/stop leave it.
- busy = (state==PLAY||state==PAUSE), registered with the state.
- rom_addr <= {frame, pix_y, pix_x} every cycle, irrespective of state; 1-cycle latency from pix_x/pix_y.
- All arithmetic is unsigned. Frame never leaves 0..FRAMES-1.
- Reset mid-playback returns to reset values immediately; no pulse is emitted.

Optional Feature:
- Macro ANIM_SEQUENCER_FRAME_SYNC_EN.
- Defined:
  - Adds input port vsync (1 bit, 1-cycle pulse at frame blank).
  - The internal frame index steps as above, but the output frame and the frame field of rom_addr update only on cycles with vsync=1. On those cycles they are loaded with the internal index, avoiding mid-screen tearing.
  - start/stop also force the displayed frame to 0 immediately.
  - busy, step_tick and done follow internal timing.
- Undefined: no vsync port; displayed frame equals the internal frame.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> frame=0, rom_addr=0, busy=0, step_tick=0, done=0. Release -> outputs stay 0 with no start.
- Loop (FRAMES=4, TICK_DIV=3, mode=00): start pulse -> frame sequence 0,1,2,3,0,1 changing every 3 cycles; step_tick high every 3rd cycle; busy=1.
- Ping-pong (mode=01): start -> frames 0,1,2,3,2,1,0,1 at 3-cycle spacing.
- One-shot (mode=10): start -> 0,1,2,3. On the 4th step_tick, done=1 for exactly one cycle, busy->0, frame stays 3. A fresh start -> frame 0, busy=1.
- Pause/stop: pause=1 after 1 PLAY cycle for 10 cycles -> frame and counter frozen, state PAUSE. pause=0 -> next step after the remaining 2 cycles. stop -> IDLE, frame 0. Simultaneous start+stop -> IDLE. rst_n low mid-PLAY -> all outputs 0 asynchronously.
- rom_addr: frame=2, pix_x=0x15, pix_y=0x7A -> rom_addr={2'd2, 8'h7A, 8'h15} one cycle later.
- With ANIM_SEQUENCER_FRAME_SYNC_EN: internal steps with no vsync -> frame output unchanged. vsync pulse -> frame jumps to the current internal index.
